// File: rtl/calc_pkg.sv
// Shared definitions for the FSM calculator datapath: control states and
// operand/result widths used by the arithmetic unit, the FSM and the divider.
package calc_pkg;

  localparam int CALC_OPND_W = 8;
  localparam int CALC_RES_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
// A zero divisor short-circuits to an all-ones quotient with div_by_zero set.
module seq_divider
  import calc_pkg::*;
#(
  parameter int DIVIDEND_W = CALC_RES_W,
  parameter int DIVISOR_W  = CALC_OPND_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVIDEND_W-1:0] q_sh;
  logic [DIVISOR_W-1:0]  dvs;
  // The partial remainder is always below the divisor, so its top bit is
  // never set between steps and only the trial value carries the extra bit.
  logic [DIVISOR_W-1:0]  prem;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    trial_sub;
  logic                  q_bit;
  logic [DIVISOR_W-1:0]  prem_next;
  logic [DIVIDEND_W-1:0] q_next;

  always_comb begin
    trial     = {prem, dvd_sh[DIVIDEND_W-1]};
    trial_sub = trial - {1'b0, dvs};
    q_bit     = (trial >= {1'b0, dvs});
    prem_next = q_bit ? trial_sub[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    q_next    = {q_sh[DIVIDEND_W-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_sh      <= '0;
      q_sh        <= '0;
      dvs         <= '0;
      prem        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd_sh      <= dividend;
            dvs         <= divisor;
            prem        <= '0;
            q_sh        <= '0;
            div_by_zero <= 1'b0;
            cnt         <= (divisor == '0) ? '0 : CNT_LAST;
            busy        <= 1'b1;
            state       <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (dvs == '0) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            prem   <= prem_next;
            q_sh   <= q_next;
            dvd_sh <= dvd_sh << 1;
            if (cnt == '0) begin
              quotient  <= q_next;
              remainder <= prem_next;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus random bench for seq_divider; expected results are queued
// when an operation is launched and compared when done pulses.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a start at the current negedge and queues the model's answer.
  task automatic applyStimulus(input logic [15:0] dd, input logic [7:0] dv);
    exp_t e;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    e.dd = dd;
    e.dv = dv;
    if (dv == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = 8'd0;
      e.dbz = 1'b1;
    end else begin
      e.q   = dd / 16'(dv);
      e.r   = 8'(dd % 16'(dv));
      e.dbz = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic pulseIgnored(input logic [15:0] dd, input logic [7:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then checks latency, busy and the queued result.
  task automatic checkOutput(input int cyc0, input int exp_lat, input int exp_busy);
    int   cyc;
    int   busy_cnt;
    exp_t e;
    cyc      = cyc0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < cyc0 + 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    if (done === 1'b1) begin
      check("latency", 32'(cyc - 1), 32'(exp_lat));
      if (exp_busy >= 0) check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
      check("busy_with_done", 32'(busy), 32'd0);
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done_cnt;
    logic [15:0] rdd;
    logic [7:0]  rdv;

    // Reset held with start asserted: reset must win.
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic operation and one-cycle done pulse.
    applyStimulus(16'd1000, 8'd7);
    checkOutput(1, 16, 16);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);

    // Boundary operands.
    applyStimulus(16'd65535, 8'd255);
    checkOutput(1, 16, 16);
    applyStimulus(16'd65535, 8'd1);
    checkOutput(1, 16, 16);
    applyStimulus(16'd5, 8'd9);
    checkOutput(1, 16, 16);

    // Divide by zero, then a normal op clears the flag.
    @(negedge clk);
    applyStimulus(16'd100, 8'd0);
    checkOutput(1, 1, -1);
    @(negedge clk);
    applyStimulus(16'd10, 8'd3);
    check("dbz_cleared_on_accept", 32'(div_by_zero), 32'd0);
    checkOutput(1, 16, 16);

    // Start during CALC is ignored; start in the done cycle is accepted.
    @(negedge clk);
    applyStimulus(16'd1000, 8'd7);
    repeat (4) @(negedge clk);
    pulseIgnored(16'd50, 8'd5);
    checkOutput(6, 16, -1);
    applyStimulus(16'd50, 8'd5);
    checkOutput(1, 16, 16);

    // Reset in the middle of an operation aborts it with no done.
    applyStimulus(16'd1000, 8'd7);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(16'd12345, 8'd97);
    checkOutput(1, 16, 16);

    // Random regression, issued back to back.
    for (int i = 0; i < 2000; i++) begin
      rdd = 16'($urandom_range(0, 65535));
      rdv = 8'($urandom_range(1, 255));
      applyStimulus(rdd, rdv);
      checkOutput(1, 16, -1);
      check("rand_identity", 32'(quotient) * 32'(rdv) + 32'(remainder), 32'(rdd));
      check("rand_rem_lt_div", 32'(remainder < rdv), 32'd1);
    end

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
